// File: rtl/cim_op_sequencer.sv
// Command sequencer driving the digital CIM macro: weight writes, compute windows, result return.
// Optional macro CIM_SEQ_PERF_EN enables the compute-latency counter on perf_cyc.
module cim_op_sequencer #(
    parameter int NPASS   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [7:0]   cmd_addr,
    input  logic [7:0]   cmd_len,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [23:0]  wr_data,
    input  logic         x_valid,
    output logic         x_ready,
    input  logic [95:0]  x_data,
    input  logic         st,
    input  logic [50:0]  nout,
    output logic [23:0]  D,
    output logic [7:0]   WA,
    output logic         cima,
    output logic         acm_en,
    output logic [95:0]  xin0,
    output logic         inwidth,
    output logic         wwidth,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [50:0]  res_data,
    output logic         busy,
    output logic         err,
    output logic [15:0]  perf_cyc
);

    localparam int PW = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WRITE    = 3'd1;
    localparam logic [2:0] S_CMP_LOAD = 3'd2;
    localparam logic [2:0] S_CMP_RUN  = 3'd3;
    localparam logic [2:0] S_CMP_WAIT = 3'd4;
    localparam logic [2:0] S_RESULT   = 3'd5;

    localparam logic [1:0] OP_WRITE   = 2'd0;
    localparam logic [1:0] OP_COMPUTE = 2'd1;
    localparam logic [1:0] OP_CFG     = 2'd2;

    logic [2:0]    state;
    logic [7:0]    row_ptr;
    logic [7:0]    beats_left;
    logic [PW-1:0] pass_cnt;
    logic [WW-1:0] wait_cnt;

    assign cmd_ready = (state == S_IDLE);
    assign wr_ready  = (state == S_WRITE);
    assign x_ready   = (state == S_CMP_LOAD);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            row_ptr    <= 8'd0;
            beats_left <= 8'd0;
            pass_cnt   <= '0;
            wait_cnt   <= '0;
            D          <= 24'd0;
            WA         <= 8'd0;
            cima       <= 1'b0;
            acm_en     <= 1'b0;
            xin0       <= 96'd0;
            inwidth    <= 1'b0;
            wwidth     <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= 51'd0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        unique case (cmd_op)
                            OP_WRITE: begin
                                row_ptr    <= cmd_addr;
                                beats_left <= cmd_len;
                                state      <= S_WRITE;
                            end
                            OP_COMPUTE: state <= S_CMP_LOAD;
                            OP_CFG: begin
                                inwidth <= cmd_addr[0];
                                wwidth  <= cmd_addr[1];
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                S_WRITE: begin
                    if (wr_valid) begin
                        D          <= wr_data;
                        WA         <= row_ptr;
                        row_ptr    <= row_ptr + 8'd1;
                        beats_left <= beats_left - 8'd1;
                        if (beats_left == 8'd0)
                            state <= S_IDLE;
                    end
                end
                S_CMP_LOAD: begin
                    if (x_valid) begin
                        xin0     <= x_data;
                        cima     <= 1'b1;
                        acm_en   <= 1'b1;
                        pass_cnt <= '0;
                        state    <= S_CMP_RUN;
                    end
                end
                S_CMP_RUN: begin
                    pass_cnt <= pass_cnt + PW'(1);
                    if (pass_cnt == PW'(NPASS - 1)) begin
                        wait_cnt <= '0;
                        state    <= S_CMP_WAIT;
                    end
                end
                S_CMP_WAIT: begin
                    wait_cnt <= wait_cnt + WW'(1);
                    // a late st on the timeout cycle still yields a result
                    if (st) begin
                        res_data  <= nout;
                        res_valid <= 1'b1;
                        acm_en    <= 1'b0;
                        state     <= S_RESULT;
                    end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                        err    <= 1'b1;
                        acm_en <= 1'b0;
                        cima   <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cima      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CIM_SEQ_PERF_EN
    logic [15:0] perf_cnt;
    logic [15:0] perf_nxt;
    logic        in_cmp;

    assign perf_nxt = (perf_cnt == 16'hFFFF) ? 16'hFFFF : perf_cnt + 16'd1;
    assign in_cmp   = (state == S_CMP_LOAD) || (state == S_CMP_RUN) ||
                      (state == S_CMP_WAIT);

    // counts the accept cycle and the res_valid rise cycle inclusively
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt <= 16'd0;
            perf_cyc <= 16'd0;
        end else if (state == S_IDLE && cmd_valid && cmd_op == OP_COMPUTE) begin
            perf_cnt <= 16'd1;
        end else if (in_cmp) begin
            perf_cnt <= perf_nxt;
            if (state == S_CMP_WAIT && st)
                perf_cyc <= perf_nxt;
        end
    end
`else
    assign perf_cyc = 16'd0;
`endif

endmodule

// File: tb/tb_cim_op_sequencer.sv
// Randomized self-checking bench for cim_op_sequencer.
// Expectations come from the command-level timing rules, not the RTL state machine.
module tb_cim_op_sequencer;

    localparam int NPASS   = 8;
    localparam int TIMEOUT = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [7:0]   cmd_addr;
    logic [7:0]   cmd_len;
    logic         wr_valid;
    logic         wr_ready;
    logic [23:0]  wr_data;
    logic         x_valid;
    logic         x_ready;
    logic [95:0]  x_data;
    logic         st;
    logic [50:0]  nout;
    logic [23:0]  D;
    logic [7:0]   WA;
    logic         cima;
    logic         acm_en;
    logic [95:0]  xin0;
    logic         inwidth;
    logic         wwidth;
    logic         res_valid;
    logic         res_ready;
    logic [50:0]  res_data;
    logic         busy;
    logic         err;
    logic [15:0]  perf_cyc;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] last_d;
    logic [7:0]  last_wa;
    logic [1:0]  exp_cfg;
    logic        exp_err;

    cim_op_sequencer #(.NPASS(NPASS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .st(st), .nout(nout),
        .D(D), .WA(WA), .cima(cima), .acm_en(acm_en), .xin0(xin0),
        .inwidth(inwidth), .wwidth(wwidth),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .err(err), .perf_cyc(perf_cyc)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] rand96();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic logic [50:0] rand51();
        return 51'({$urandom, $urandom});
    endfunction

    task automatic issue_cmd(input logic [1:0] op, input logic [7:0] addr,
                             input logic [7:0] len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_len   = len;
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready=%b want 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, err, res_valid, acm_en, cima, wr_ready, x_ready,
             inwidth, wwidth, cmd_ready} !== 10'b0000000001) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b err=%b rv=%b acm=%b cima=%b cmd_ready=%b want 0..0,1",
                     busy, err, res_valid, acm_en, cima, cmd_ready);
        end
        n_tests++;
        if (D !== 24'd0 || WA !== 8'd0 || xin0 !== 96'd0 ||
            res_data !== 51'd0 || perf_cyc !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: D=%h WA=%h res=%h perf=%0d want 0", D, WA, res_data, perf_cyc);
        end
        rst = 1'b0;
        last_d  = 24'd0;
        last_wa = 8'd0;
        exp_cfg = 2'b00;
        exp_err = 1'b0;
    endtask

    task automatic test_write(input logic [7:0] addr, input logic [7:0] len);
        logic [23:0] data;
        logic [7:0]  exp_wa;
        issue_cmd(2'd0, addr, len);
        n_tests++;
        if (busy !== 1'b1 || wr_ready !== 1'b1 || cima !== 1'b0 || acm_en !== 1'b0) begin
            n_fail++;
            $display("FAIL write_enter: busy=%b wr_ready=%b cima=%b acm=%b want 1,1,0,0",
                     busy, wr_ready, cima, acm_en);
        end
        for (int i = 0; i <= int'(len); i++) begin
            int gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                wr_valid = 1'b0;
                wr_data  = 24'($urandom);
                @(negedge clk);
            end
            data     = 24'($urandom);
            exp_wa   = addr + 8'(i);
            wr_valid = 1'b1;
            wr_data  = data;
            @(negedge clk);
            wr_valid = 1'b0;
            n_tests++;
            if (WA !== exp_wa || D !== data) begin
                n_fail++;
                $display("FAIL write_beat%0d: WA=%h D=%h want WA=%h D=%h", i, WA, D, exp_wa, data);
            end
            last_d  = data;
            last_wa = exp_wa;
        end
        n_tests++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL write_done: busy=%b cmd_ready=%b wr_ready=%b want 0,1,0",
                     busy, cmd_ready, wr_ready);
        end
    endtask

    task automatic test_cfg(input logic [1:0] v);
        issue_cmd(2'd2, {6'($urandom), v}, 8'($urandom));
        exp_cfg = v;
        n_tests++;
        if (inwidth !== v[0] || wwidth !== v[1] || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg: inwidth=%b wwidth=%b cmd_ready=%b busy=%b want %b,%b,1,0",
                     inwidth, wwidth, cmd_ready, busy, v[0], v[1]);
        end
    endtask

    task automatic test_compute(input int w, input int d, input int r,
                                input logic [95:0] xv, input logic [50:0] nv,
                                input bit noise);
        int rise;
        int acm;
        bit hold_ok;
        logic [15:0] exp_perf;
        issue_cmd(2'd1, 8'($urandom), 8'($urandom));
        n_tests++;
        if (busy !== 1'b1 || x_ready !== 1'b1 || cmd_ready !== 1'b0 || acm_en !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_load: busy=%b x_ready=%b cmd_ready=%b acm=%b want 1,1,0,0",
                     busy, x_ready, cmd_ready, acm_en);
        end
        for (int i = 0; i < d; i++) begin
            x_valid = 1'b0;
            x_data  = rand96();
            @(negedge clk);
        end
        x_valid = 1'b1;
        x_data  = xv;
        @(negedge clk);
        x_valid = 1'b0;
        x_data  = rand96();
        n_tests++;
        if (xin0 !== xv || cima !== 1'b1 || x_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_xin: xin0=%h cima=%b x_ready=%b want %h,1,0", xin0, cima, x_ready, xv);
        end
        rise = -1;
        acm  = 0;
        for (int j = 0; j < NPASS + w + 64 && rise < 0; j++) begin
            if (acm_en === 1'b1) acm++;
            if (res_valid === 1'b1) begin
                rise = j;
            end else begin
                if (j == NPASS + w - 1) begin
                    st   = 1'b1;
                    nout = nv;
                end else begin
                    st   = (noise && j < NPASS) ? 1'($urandom) : 1'b0;
                    nout = rand51();
                end
                @(negedge clk);
            end
        end
        st   = 1'b0;
        nout = rand51();
        n_tests++;
        if (rise != NPASS + w) begin
            n_fail++;
            $display("FAIL cmp_latency: res_valid after %0d cycles want %0d", rise, NPASS + w);
        end
        n_tests++;
        if (acm != NPASS + w) begin
            n_fail++;
            $display("FAIL cmp_acm_len: acm_en high %0d cycles want %0d", acm, NPASS + w);
        end
        n_tests++;
        if (res_data !== nv || cima !== 1'b1 || {inwidth, wwidth} !== {exp_cfg[0], exp_cfg[1]}) begin
            n_fail++;
            $display("FAIL cmp_result: res_data=%h cima=%b cfg=%b%b want %h,1,%b%b",
                     res_data, cima, inwidth, wwidth, nv, exp_cfg[0], exp_cfg[1]);
        end
`ifdef CIM_SEQ_PERF_EN
        exp_perf = 16'(2 + d + NPASS + w);
`else
        exp_perf = 16'd0;
`endif
        n_tests++;
        if (perf_cyc !== exp_perf) begin
            n_fail++;
            $display("FAIL cmp_perf: perf_cyc=%0d want %0d", perf_cyc, exp_perf);
        end
        hold_ok = 1'b1;
        for (int i = 0; i < r; i++) begin
            res_ready = 1'b0;
            nout = rand51();
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== nv) hold_ok = 1'b0;
        end
        n_tests++;
        if (!hold_ok) begin
            n_fail++;
            $display("FAIL cmp_hold: res_valid=%b res_data=%h want 1,%h", res_valid, res_data, nv);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_tests++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || cima !== 1'b0 ||
            acm_en !== 1'b0 || cmd_ready !== 1'b1 || err !== exp_err) begin
            n_fail++;
            $display("FAIL cmp_done: rv=%b busy=%b cima=%b acm=%b cmd_ready=%b err=%b want 0,0,0,0,1,%b",
                     res_valid, busy, cima, acm_en, cmd_ready, err, exp_err);
        end
        n_tests++;
        if (xin0 !== xv || D !== last_d || WA !== last_wa) begin
            n_fail++;
            $display("FAIL cmp_keep: xin0=%h D=%h WA=%h want %h,%h,%h", xin0, D, WA, xv, last_d, last_wa);
        end
    endtask

    task automatic test_timeout();
        int idle_j;
        int acm;
        bit saw_res;
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pre: err=%b want 0", err);
        end
        issue_cmd(2'd1, 8'd0, 8'd0);
        x_valid = 1'b1;
        x_data  = rand96();
        @(negedge clk);
        x_valid = 1'b0;
        st      = 1'b0;
        idle_j  = -1;
        acm     = 0;
        saw_res = 1'b0;
        for (int j = 0; j < NPASS + TIMEOUT + 64 && idle_j < 0; j++) begin
            if (acm_en === 1'b1) acm++;
            if (res_valid === 1'b1) saw_res = 1'b1;
            if (busy === 1'b0) idle_j = j;
            else @(negedge clk);
        end
        exp_err = 1'b1;
        n_tests++;
        if (idle_j != NPASS + TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_len: idle after %0d cycles want %0d", idle_j, NPASS + TIMEOUT);
        end
        n_tests++;
        if (acm != NPASS + TIMEOUT || saw_res) begin
            n_fail++;
            $display("FAIL timeout_acm: acm cycles=%0d res_seen=%b want %0d,0", acm, saw_res, NPASS + TIMEOUT);
        end
        n_tests++;
        if (err !== 1'b1 || acm_en !== 1'b0 || cima !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_end: err=%b acm=%b cima=%b rv=%b want 1,0,0,0",
                     err, acm_en, cima, res_valid);
        end
    endtask

    task automatic test_reserved();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        exp_cfg = 2'b00;
        last_d  = 24'd0;
        last_wa = 8'd0;
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL rsv_pre: err=%b want 0 after reset", err);
        end
        issue_cmd(2'd3, 8'($urandom), 8'($urandom));
        exp_err = 1'b1;
        @(negedge clk);
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rsv_op: err=%b busy=%b cmd_ready=%b want 1,0,1", err, busy, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        issue_cmd(2'd1, 8'd0, 8'd0);
        x_valid = 1'b1;
        x_data  = rand96();
        @(negedge clk);
        x_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (acm_en !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_pre: acm=%b busy=%b want 1,1", acm_en, busy);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, err, res_valid, acm_en, cima, wr_ready, x_ready,
             inwidth, wwidth, cmd_ready} !== 10'b0000000001 ||
            xin0 !== 96'd0 || D !== 24'd0 || WA !== 8'd0 || perf_cyc !== 16'd0) begin
            n_fail++;
            $display("FAIL midrun_rst: busy=%b err=%b acm=%b cima=%b cmd_ready=%b xin0=%h want 0s,1",
                     busy, err, acm_en, cima, cmd_ready, xin0);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        exp_cfg = 2'b00;
        last_d  = 24'd0;
        last_wa = 8'd0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = 8'd0;
        cmd_len   = 8'd0;
        wr_valid  = 1'b0;
        wr_data   = 24'd0;
        x_valid   = 1'b0;
        x_data    = 96'd0;
        st        = 1'b0;
        nout      = 51'd0;
        res_ready = 1'b0;

        test_reset();
        test_write(8'hFE, 8'd2);
        repeat (3) test_write(8'($urandom), 8'($urandom_range(0, 15)));
        test_cfg(2'b10);
        test_cfg(2'($urandom));
        test_compute(3, 0, 4, 96'h1, 51'h5, 1'b0);
        repeat (4) test_compute($urandom_range(1, 20), $urandom_range(0, 3),
                                $urandom_range(0, 5), rand96(), rand51(), 1'b1);
        test_write(8'($urandom), 8'($urandom_range(0, 7)));
        test_compute(1, 2, 0, rand96(), rand51(), 1'b0);
        test_timeout();
        test_reserved();
        test_reset_mid_run();
        test_compute(2, 1, 1, rand96(), rand51(), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
